// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the program/data memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DEF     = 8;
   localparam int DATA_W_DEF     = 8;
   localparam int MAX_STREAK_DEF = 4;

   typedef enum logic {ARB, LOCKED} arb_state_t;

   typedef enum logic [1:0] {SEL_NONE, SEL_C, SEL_D} port_sel_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between CPU port C and loader port D; grants are
// combinational (0 cycles), read data returns 1 cycle later, losers are stalled.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int MAX_STREAK = MAX_STREAK_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_c_req,
   input  logic              i_c_we,
   input  logic [ADDR_W-1:0] i_c_addr,
   input  logic [DATA_W-1:0] i_c_wdata,
   input  logic              i_d_req,
   input  logic              i_d_we,
   input  logic [ADDR_W-1:0] i_d_addr,
   input  logic [DATA_W-1:0] i_d_wdata,
   input  logic              i_d_lock,
   output logic              o_c_gnt,
   output logic              o_d_gnt,
   output logic              o_c_rvalid,
   output logic              o_d_rvalid,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_c_stall,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   localparam int              SW         = $clog2(MAX_STREAK + 1);
   localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_STREAK);

   arb_state_t    state, state_nxt;
   logic [SW-1:0] streak, streak_nxt;
   port_sel_t     sel;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= ARB;
         streak     <= '0;
         o_c_rvalid <= 1'b0;
         o_d_rvalid <= 1'b0;
      end else begin
         state      <= state_nxt;
         streak     <= streak_nxt;
         o_c_rvalid <= o_c_gnt & ~i_c_we;
         o_d_rvalid <= o_d_gnt & ~i_d_we;
      end
   end

   // Under contention C wins until it has taken MAX_STREAK grants in a row.
   always_comb begin
      sel = SEL_NONE;
      if (state == LOCKED) begin
         if (i_d_req) sel = SEL_D;
      end else if (i_c_req && i_d_req) begin
         sel = (streak == STREAK_MAX) ? SEL_D : SEL_C;
      end else if (i_c_req) begin
         sel = SEL_C;
      end else if (i_d_req) begin
         sel = SEL_D;
      end
   end

   always_comb begin
      o_c_gnt     = (sel == SEL_C);
      o_d_gnt     = (sel == SEL_D);
      o_c_stall   = i_c_req & ~o_c_gnt;
      o_mem_en    = o_c_gnt | o_d_gnt;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      case (sel)
         SEL_C: begin
            o_mem_we    = i_c_we;
            o_mem_addr  = i_c_addr;
            o_mem_wdata = i_c_wdata;
         end
         SEL_D: begin
            o_mem_we    = i_d_we;
            o_mem_addr  = i_d_addr;
            o_mem_wdata = i_d_wdata;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ARB:     if (o_d_gnt && i_d_lock) state_nxt = LOCKED;
         LOCKED:  if (!i_d_lock) state_nxt = ARB;
         default: state_nxt = ARB;
      endcase
   end

   always_comb begin
      streak_nxt = streak;
      if (o_d_gnt || !i_d_req) begin
         streak_nxt = '0;
      end else if (o_c_gnt && streak != STREAK_MAX) begin
         streak_nxt = streak + 1'b1;
      end
   end

   assign o_rdata = i_mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous RAM.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       c_req, c_we, d_req, d_we, d_lock;
   logic [7:0] c_addr, c_wdata, d_addr, d_wdata;
   logic       c_gnt, d_gnt, c_rvalid, d_rvalid, c_stall;
   logic       mem_en, mem_we;
   logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic [7:0] mem [256];

   int total = 0;
   int bad   = 0;

   mem_arbiter dut (
      .i_clk(clk), .i_rst(rst),
      .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
      .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
      .i_d_lock(d_lock),
      .o_c_gnt(c_gnt), .o_d_gnt(d_gnt), .o_c_rvalid(c_rvalid), .o_d_rvalid(d_rvalid),
      .o_rdata(rdata), .o_c_stall(c_stall),
      .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) mem[8'h10] <= 8'h5A;
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      #1;
      total++; if (c_rvalid !== 1'b0) begin bad++; $display("FAIL rst_c_rvalid got=%b exp=0", c_rvalid); end
      total++; if (d_rvalid !== 1'b0) begin bad++; $display("FAIL rst_d_rvalid got=%b exp=0", d_rvalid); end
      total++; if (c_gnt !== 1'b0 || d_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%b%b exp=00", c_gnt, d_gnt); end
      total++; if (mem_en !== 1'b0 || mem_addr !== 8'h00) begin bad++; $display("FAIL rst_mem got en=%b addr=%h exp en=0 addr=00", mem_en, mem_addr); end
      total++; if (dut.state !== ARB || dut.streak !== 3'd0) begin bad++; $display("FAIL rst_state got st=%0d sk=%0d exp st=0 sk=0", dut.state, dut.streak); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_c_read();
      c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10;
      #1;
      total++; if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin bad++; $display("FAIL cread_gnt got c=%b d=%b exp c=1 d=0", c_gnt, d_gnt); end
      total++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h10) begin bad++; $display("FAIL cread_mem got en=%b we=%b addr=%h exp 1 0 10", mem_en, mem_we, mem_addr); end
      total++; if (c_stall !== 1'b0) begin bad++; $display("FAIL cread_stall got=%b exp=0", c_stall); end
      tick();
      c_req = 1'b0;
      #1;
      total++; if (c_rvalid !== 1'b1 || rdata !== 8'h5A) begin bad++; $display("FAIL cread_data got v=%b d=%h exp v=1 d=5a", c_rvalid, rdata); end
      total++; if (d_rvalid !== 1'b0) begin bad++; $display("FAIL cread_d_rvalid got=%b exp=0", d_rvalid); end
      tick();
      total++; if (c_rvalid !== 1'b0) begin bad++; $display("FAIL cread_pulse got=%b exp=0", c_rvalid); end
   endtask

   task automatic test_streak();
      logic exp_d, prev_c, prev_d;
      prev_c = 1'b0; prev_d = 1'b0;
      c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10;
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10; d_lock = 1'b0;
      for (int i = 0; i < 10; i++) begin
         exp_d = (i % 5 == 4);
         #1;
         total++; if (c_gnt !== !exp_d || d_gnt !== exp_d || c_stall !== exp_d) begin
            bad++; $display("FAIL streak_gnt i=%0d got c=%b d=%b stall=%b exp c=%b d=%b stall=%b", i, c_gnt, d_gnt, c_stall, !exp_d, exp_d, exp_d);
         end
         total++; if (c_rvalid !== prev_c || d_rvalid !== prev_d) begin
            bad++; $display("FAIL streak_rvalid i=%0d got c=%b d=%b exp c=%b d=%b", i, c_rvalid, d_rvalid, prev_c, prev_d);
         end
         prev_c = !exp_d; prev_d = exp_d;
         tick();
      end
      c_req = 1'b0; d_req = 1'b0;
      tick();
   endtask

   task automatic test_lock_burst();
      for (int k = 0; k < 8; k++) begin
         d_req = 1'b1; d_we = 1'b1; d_addr = 8'h80 + 8'(k); d_wdata = 8'(k + 1);
         d_lock = (k < 7);
         c_req = (k >= 1); c_we = 1'b0; c_addr = 8'h10;
         #1;
         total++; if (d_gnt !== 1'b1 || c_gnt !== 1'b0 || c_stall !== (k >= 1)) begin
            bad++; $display("FAIL lock_burst k=%0d got d=%b c=%b stall=%b exp d=1 c=0 stall=%b", k, d_gnt, c_gnt, c_stall, (k >= 1));
         end
         tick();
      end
      d_req = 1'b0; d_lock = 1'b0; d_we = 1'b0;
      #1;
      total++; if (c_gnt !== 1'b1) begin bad++; $display("FAIL lock_release got c=%b exp=1", c_gnt); end
      tick();
      c_req = 1'b0;
      for (int k = 0; k < 8; k++) begin
         total++; if (mem[8'h80 + 8'(k)] !== 8'(k + 1)) begin
            bad++; $display("FAIL lock_mem addr=%h got=%h exp=%h", 8'h80 + 8'(k), mem[8'h80 + 8'(k)], 8'(k + 1));
         end
      end
      tick();
   endtask

   task automatic test_lock_lose();
      c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10;
      d_req = 1'b1; d_we = 1'b1; d_addr = 8'h90; d_wdata = 8'hAA; d_lock = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin bad++; $display("FAIL lose_gnt i=%0d got c=%b d=%b exp c=1 d=0", i, c_gnt, d_gnt); end
         tick();
         total++; if (dut.state !== ARB) begin bad++; $display("FAIL lose_state i=%0d got=%0d exp=0", i, dut.state); end
      end
      #1;
      total++; if (d_gnt !== 1'b1 || c_gnt !== 1'b0) begin bad++; $display("FAIL lose_dwin got c=%b d=%b exp c=0 d=1", c_gnt, d_gnt); end
      tick();
      total++; if (dut.state !== LOCKED) begin bad++; $display("FAIL lose_locked got=%0d exp=1", dut.state); end
      d_req = 1'b0; d_lock = 1'b0;
      #1;
      total++; if (c_gnt !== 1'b0 || c_stall !== 1'b1) begin bad++; $display("FAIL lose_cblock got gnt=%b stall=%b exp 0 1", c_gnt, c_stall); end
      tick();
      #1;
      total++; if (c_gnt !== 1'b1 || mem[8'h90] !== 8'hAA) begin bad++; $display("FAIL lose_after got gnt=%b mem=%h exp 1 aa", c_gnt, mem[8'h90]); end
      c_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10;
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10; d_lock = 1'b0;
      tick();
      tick();
      total++; if (dut.streak !== 3'd2) begin bad++; $display("FAIL rmid_streak got=%0d exp=2", dut.streak); end
      rst = 1'b1;
      #1;
      total++; if (c_rvalid !== 1'b1) begin bad++; $display("FAIL rmid_pending got=%b exp=1", c_rvalid); end
      tick();
      total++; if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin bad++; $display("FAIL rmid_rvalid got c=%b d=%b exp 0 0", c_rvalid, d_rvalid); end
      total++; if (dut.streak !== 3'd0 || dut.state !== ARB) begin bad++; $display("FAIL rmid_state got sk=%0d st=%0d exp 0 0", dut.streak, dut.state); end
      rst = 1'b0; c_req = 1'b0;
      d_we = 1'b1; d_addr = 8'h91; d_wdata = 8'h11; d_lock = 1'b1;
      tick();
      total++; if (dut.state !== LOCKED) begin bad++; $display("FAIL rmid_lock got=%0d exp=1", dut.state); end
      rst = 1'b1;
      tick();
      total++; if (dut.state !== ARB) begin bad++; $display("FAIL rmid_unlock got=%0d exp=0", dut.state); end
      rst = 1'b0; d_req = 1'b0; d_lock = 1'b0; d_we = 1'b0;
      tick();
   endtask

   task automatic test_alternate();
      c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10;
      #1;
      total++; if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin bad++; $display("FAIL alt_c1 got c=%b d=%b exp 1 0", c_gnt, d_gnt); end
      tick();
      c_req = 1'b0;
      d_req = 1'b1; d_we = 1'b1; d_addr = 8'h30; d_wdata = 8'h77;
      #1;
      total++; if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h30 || mem_wdata !== 8'h77) begin
         bad++; $display("FAIL alt_d2 got gnt=%b we=%b addr=%h wd=%h exp 1 1 30 77", d_gnt, mem_we, mem_addr, mem_wdata);
      end
      total++; if (c_rvalid !== 1'b1 || d_rvalid !== 1'b0 || rdata !== 8'h5A) begin
         bad++; $display("FAIL alt_r1 got c=%b d=%b data=%h exp 1 0 5a", c_rvalid, d_rvalid, rdata);
      end
      tick();
      d_req = 1'b0; d_we = 1'b0;
      c_req = 1'b1; c_we = 1'b1; c_addr = 8'h31; c_wdata = 8'h66;
      #1;
      total++; if (c_gnt !== 1'b1 || mem_we !== 1'b1 || c_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
         bad++; $display("FAIL alt_c3 got gnt=%b we=%b cv=%b dv=%b exp 1 1 0 0", c_gnt, mem_we, c_rvalid, d_rvalid);
      end
      tick();
      c_req = 1'b0; c_we = 1'b0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30;
      #1;
      total++; if (d_gnt !== 1'b1 || c_rvalid !== 1'b0) begin bad++; $display("FAIL alt_d4 got gnt=%b cv=%b exp 1 0", d_gnt, c_rvalid); end
      tick();
      d_req = 1'b0;
      #1;
      total++; if (d_rvalid !== 1'b1 || c_rvalid !== 1'b0 || rdata !== 8'h77) begin
         bad++; $display("FAIL alt_r4 got d=%b c=%b data=%h exp 1 0 77", d_rvalid, c_rvalid, rdata);
      end
      total++; if (mem[8'h31] !== 8'h66) begin bad++; $display("FAIL alt_mem got=%h exp=66", mem[8'h31]); end
      tick();
      total++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00 || d_rvalid !== 1'b0) begin
         bad++; $display("FAIL alt_idle got en=%b we=%b addr=%h wd=%h dv=%b exp 0 0 00 00 0", mem_en, mem_we, mem_addr, mem_wdata, d_rvalid);
      end
   endtask

   initial begin
      rst = 1'b1;
      c_req = 1'b0; c_we = 1'b0; c_addr = 8'h00; c_wdata = 8'h00;
      d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 8'h00; d_lock = 1'b0;
      test_reset();
      test_c_read();
      test_streak();
      test_lock_burst();
      test_lock_lose();
      test_reset_mid();
      test_alternate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
